// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester NOT/SHR ALU arbiter.
// Optional zero-result statistics are enabled with ALU_ARB_ZERO_STAT_EN.
package alu_arb_pkg;

  localparam int W   = 7;
  localparam int OPW = 1;

  localparam logic [OPW-1:0] OP_NOT = 1'b0;
  localparam logic [OPW-1:0] OP_SHR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response handshake bundle between two requesters and the ALU arbiter.
// Requesters connect through the master modport, the arbiter through slave.
interface alu_share_arbiter_if #(
  parameter int W   = alu_arb_pkg::W,
  parameter int OPW = alu_arb_pkg::OPW
);

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   req_a0;
  logic [W-1:0]   req_b0;
  logic [OPW-1:0] req_op0;
  logic [W-1:0]   req_a1;
  logic [W-1:0]   req_b1;
  logic [OPW-1:0] req_op1;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [W-1:0]   resp_data;
  logic           resp_zero;

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_zero
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
    output req_ready, resp_valid, resp_data, resp_zero
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational NOT/SHR ALU between two requesters.
// Define ALU_ARB_ZERO_STAT_EN to add the saturating zero-result counter.
module alu_share_arbiter #(
  parameter int W   = alu_arb_pkg::W,
  parameter int OPW = alu_arb_pkg::OPW
) (
  input  logic           clk,
  input  logic           reset_n,
  alu_share_arbiter_if.slave bus,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_zero,
  output logic           busy
`ifdef ALU_ARB_ZERO_STAT_EN
  ,
  input  logic           zero_count_clr,
  output logic [7:0]     zero_count
`endif
);

  import alu_arb_pkg::*;

  state_t     state;
  state_t     nxt_state;
  logic       owner;
  logic       last_grant;
  logic [1:0] grant;
  logic       req_fire;
  logic       resp_fire;

  rr_arb2 u_rr_arb2 (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // grant is always a subset of req_valid, so any grant in IDLE is a handshake
  assign req_fire  = (state == IDLE) && (grant != 2'b00);
  assign resp_fire = (state == RESP) && bus.resp_ready[owner];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (req_fire)  nxt_state = ISSUE;
      ISSUE:                  nxt_state = RESP;
      RESP:    if (resp_fire) nxt_state = IDLE;
      default:                nxt_state = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 2'b00;
    bus.resp_valid = 2'b00;
    busy           = 1'b0;
    case (state)
      IDLE:    bus.req_ready = grant;
      ISSUE:   busy = 1'b1;
      RESP: begin
        busy           = 1'b1;
        bus.resp_valid = id_onehot(owner);
      end
      default: busy = 1'b1;
    endcase
  end

  // Operand registers only load on a request handshake, so the ALU inputs
  // stay quiet outside ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      bus.resp_data <= '0;
      bus.resp_zero <= 1'b0;
    end else begin
      if (req_fire) begin
        alu_a  <= grant[1] ? bus.req_a1  : bus.req_a0;
        alu_b  <= grant[1] ? bus.req_b1  : bus.req_b0;
        alu_op <= grant[1] ? bus.req_op1 : bus.req_op0;
        owner  <= grant[1];
      end
      if (state == ISSUE) begin
        bus.resp_data <= alu_result;
        bus.resp_zero <= alu_zero;
      end
      if (resp_fire) last_grant <= owner;
    end
  end

`ifdef ALU_ARB_ZERO_STAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_count <= 8'd0;
    end else if (zero_count_clr) begin
      zero_count <= 8'd0;
    end else if (resp_fire && bus.resp_zero && (zero_count != 8'hFF)) begin
      zero_count <= zero_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Arbitrates one shared W-bit NOT/SHR ALU between two requesters (0 and 1).
- Each requester issues an operand pair plus opcode over a valid/ready handshake.
- The block sequences the operation through the ALU and returns the result and zero flag over a per-requester valid/ready response handshake.
- Sits between the test/sequence controllers and the ALU datapath; the ALU itself is external and purely combinational.

Parameters:
- W, 7, operand/result width (ALU A, B, result).
- OPW, 1, opcode width (0 = NOT, 1 = SHR).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_a0, req_b0  in  W  requester 0 operands.
- req_op0  in  OPW  requester 0 opcode.
- req_a1, req_b1  in  W  requester 1 operands.
- req_op1  in  OPW  requester 1 opcode.
- resp_valid  out  2  per-requester response valid.
- resp_ready  in  2  per-requester response accept.
- resp_data  out  W  shared result bus, valid only with resp_valid.
- resp_zero  out  1  result == 0.
- alu_a, alu_b  out  W  registered operands to ALU.
- alu_op  out  OPW  registered opcode to ALU.
- alu_result  in  W  ALU result (combinational from alu_a/b/op).
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n low, async): state = IDLE; alu_a, alu_b, alu_op, resp_data, resp_zero, resp_valid and busy = 0; last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, arbitration:
  - Grant = the only valid requester; if both are valid, the one != last_grant.
  - req_ready[grant] = 1 combinationally in IDLE only.
  - On handshake: register the granted operands into alu_a/alu_b/alu_op, store the owner id, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - ALU is driven from the registered operands.
  - At the clock edge, capture alu_result into resp_data and alu_zero into resp_zero; go to RESP.
- RESP:
  - resp_valid[owner] = 1; resp_data/resp_zero are held stable.
  - On resp_ready[owner]: clear resp_valid, set last_grant = owner, go to IDLE.
  - resp_ready on the non-owner bit is ignored.
- req_ready = 0 outside IDLE; requests arriving in ISSUE/RESP wait (requesters must hold valid and data until ready).
- Latency: handshake at edge N -> resp_valid high from cycle N+2. Minimum throughput: one op per 3 cycles.
- alu_a/alu_b/alu_op keep their last values outside ISSUE (no toggling).
- Simultaneous valid after a served op: alternates strictly, with no starvation.
- Reset mid-operation: the in-flight op is discarded, no response is issued, and arbitration restarts with requester 0 priority.

Optional Feature:
- Macro: ALU_ARB_ZERO_STAT_EN.
- When defined:
  - Adds output zero_count (8 bits), a saturating count (stops at 255) of completed responses with resp_zero = 1, incremented on the response handshake.
  - Adds input zero_count_clr (1 bit), a synchronous clear that wins over increment.
  - zero_count resets to 0.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package alu_arb_pkg:
  - state enum (IDLE/ISSUE/RESP);
  - opcode constants OP_NOT = 0, OP_SHR = 1;
  - default widths W = 7, OPW = 1.
- One natural sub-module: rr_arb2, the 2-way round-robin grant logic (inputs req_valid and last_grant, output one-hot grant). Everything else stays in the top.

Test Plan:
1. Single NOT: req0 A=1010101, op=0. Expect req_ready[0] in IDLE; resp_valid[0] two cycles after the handshake; resp_data=0101010, resp_zero=0.
2. SHR to zero: req1 A=0000001, B=0000111, op=1. Expect resp_valid[1], resp_data=0000000, resp_zero=1.
3. Contention: both valid from reset (req0 SHR 1100110>>1, req1 NOT 0000000). Expect req0 served first (0110011), then req1 (1111111). With both held valid, grants alternate 0,1,0,1 over 4 ops.
4. Backpressure: hold resp_ready low 5 cycles in RESP. Expect resp_valid/resp_data stable, busy=1, req_ready=0, and no second accept until the response handshake.
5. Reset mid-op: assert reset_n low during ISSUE. Expect all outputs 0 immediately; after release, no stale response, and requester 0 wins the next contention.
6. ALU_ARB_ZERO_STAT_EN: run 3 zero-result ops, then pulse zero_count_clr. Expect zero_count 1,2,3 then 0; forcing 256 zero results yields saturation at 255.
